// File: rtl/tausworthe_urng.sv
// Combined three-component Tausworthe (taus88) step: advances the caller's
// three component states by one step, XORs them and registers the sample.
module tausworthe_urng #(
  parameter int unsigned Bus_size = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Bus_size:0]   t0,
  input  logic [Bus_size:0]   t1,
  input  logic [Bus_size:0]   t2,
  output logic [Bus_size:0]   t_out
);

  logic [31:0] b1, b2, b3;
  logic [31:0] n1, n2, n3;
  logic [31:0] t_out_d;
  logic [31:0] t_out_q;

  // Shift and mask constants are fixed for 32-bit components.
  always_comb begin
    b1 = ((t0 << 13) ^ t0) >> 19;
    n1 = ((t0 & 32'hFFFF_FFFE) << 12) ^ b1;

    b2 = ((t1 << 2) ^ t1) >> 25;
    n2 = ((t1 & 32'hFFFF_FFF8) << 4) ^ b2;

    b3 = ((t2 << 3) ^ t2) >> 11;
    n3 = ((t2 & 32'hFFFF_FFF0) << 17) ^ b3;

    t_out_d = n1 ^ n2 ^ n3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_out_q <= '0;
    end else begin
      t_out_q <= t_out_d;
    end
  end

  assign t_out = t_out_q;

endmodule

// File: tb/tb_tausworthe_urng.sv
// Directed and streamed checks of the taus88 step against a scoreboard of
// expected samples queued as each input triple is presented.
module tb_tausworthe_urng;

  logic        clk;
  logic        rst;
  logic [31:0] t0, t1, t2;
  logic [31:0] t_out;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [31:0] exp_q[$];

  tausworthe_urng #(.Bus_size(31)) dut (
    .clk  (clk),
    .rst  (rst),
    .t0   (t0),
    .t1   (t1),
    .t2   (t2),
    .t_out(t_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] taus88(input logic [31:0] s1,
                                         input logic [31:0] s2,
                                         input logic [31:0] s3);
    logic [31:0] m1, m2, m3;
    m1 = (((s1 << 13) ^ s1) >> 19) ^ ((s1 & 32'hFFFF_FFFE) << 12);
    m2 = (((s2 << 2)  ^ s2) >> 25) ^ ((s2 & 32'hFFFF_FFF8) << 4);
    m3 = (((s3 << 3)  ^ s3) >> 11) ^ ((s3 & 32'hFFFF_FFF0) << 17);
    return m1 ^ m2 ^ m3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Present a triple before the edge, queue its expected sample, compare after the edge.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] expv);
    logic [31:0] e;
    @(negedge clk);
    t0 = a; t1 = b; t2 = c;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, t_out, 32'hDEAD_BEEF ^ t_out ^ 32'h1);
    end else begin
      e = exp_q.pop_front();
      check(tag, t_out, e);
    end
  endtask

  initial begin
    logic [31:0] a, b, c;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    t0 = '0; t1 = '0; t2 = '0;

    #2;
    check("reset_no_clock", t_out, 32'h0000_0000);
    t0 = 32'hFFFF_FFFF; t1 = 32'h1234_5678; t2 = 32'h9ABC_DEF0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", t_out, 32'h0000_0000);

    @(negedge clk);
    t0 = '0; t1 = '0; t2 = '0;
    rst = 1'b1;
    step("zero_seed_0", 32'h0, 32'h0, 32'h0, 32'h0000_0000);
    step("zero_seed_1", 32'h0, 32'h0, 32'h0, 32'h0000_0000);

    step("min_seeds",   32'h2, 32'h8, 32'h10, 32'h0020_2080);
    step("masked_low",  32'h1, 32'h1, 32'h1,  32'h0000_0000);
    step("msb_only",    32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0010_1040);
    step("s1_all_ones", 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_E000);

    // Asynchronous reset in the middle of a cycle, away from any edge.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", t_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reset_edge_held", t_out, 32'h0000_0000);

    @(negedge clk);
    t0 = 32'h2; t1 = 32'h8; t2 = 32'h10;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_reset", t_out, 32'h0020_2080);

    // Back-to-back stream against the software model.
    for (int i = 0; i < 10; i++) begin
      a = $urandom() | 32'h0000_0002;
      b = $urandom() | 32'h0000_0008;
      c = $urandom() | 32'h0000_0010;
      step($sformatf("stream_%0d", i), a, b, c, taus88(a, b, c));
    end

    n_checks++;
    assert (exp_q.size() == 0) n_pass++;
    else $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
